// File: rtl/uart_cfg.sv
// UART with runtime baud divisor, parity and stop-bit selection, oversampled RX/TX engines
// behind first-word fall-through FIFOs; RX words carry parity/framing error flags.
module uart_cfg #(
    parameter int unsigned DBIT     = 8,
    parameter int unsigned DVSR_BIT = 11,
    parameter int unsigned FIFO_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DVSR_BIT-1:0] dvsr,
    input  logic [1:0]          parity_mode,
    input  logic                stop2,
    input  logic                rx,
    input  logic                rd_uart,
    output logic [DBIT-1:0]     r_data,
    output logic                r_perr,
    output logic                r_ferr,
    output logic                rx_empty,
    output logic [FIFO_W:0]     rx_level,
    output logic                overrun,
    input  logic                clr_ovr,
    input  logic                wr_uart,
    input  logic [DBIT-1:0]     w_data,
    output logic                tx_full,
    output logic [FIFO_W:0]     tx_level,
    output logic                tx_busy,
    output logic                tx
);
    localparam int unsigned    DEPTH    = 2 ** FIFO_W;
    localparam int unsigned    RXW      = DBIT + 2;
    localparam logic [FIFO_W:0] LVL_FULL = (FIFO_W + 1)'(DEPTH);
    localparam logic [2:0]     LAST_BIT = 3'(DBIT - 1);

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

    // Baud generator; the divisor is re-sampled only at wrap.
    logic [DVSR_BIT-1:0] r_baud_cnt, r_dvsr;
    logic                w_tick;
    assign w_tick = (r_baud_cnt == r_dvsr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_baud_cnt <= '0;
            r_dvsr     <= '0;
        end else if (w_tick) begin
            r_baud_cnt <= '0;
            r_dvsr     <= dvsr;
        end else begin
            r_baud_cnt <= r_baud_cnt + DVSR_BIT'(1);
        end
    end

    logic r_rx_meta, r_rx_sync;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // RX engine
    rx_state_e       r_rx_state, w_rx_state_d;
    logic [3:0]      r_rx_s, w_rx_s_d;
    logic [2:0]      r_rx_n, w_rx_n_d;
    logic [DBIT-1:0] r_rx_b, w_rx_b_d;
    logic [1:0]      r_rx_pm, w_rx_pm_d;
    logic            r_rx_perr, w_rx_perr_d;
    logic            w_rx_push, w_rx_par_en, w_rx_odd;
    logic [RXW-1:0]  w_rx_word;

    assign w_rx_par_en = (r_rx_pm == 2'b01) || (r_rx_pm == 2'b10);
    assign w_rx_odd    = (r_rx_pm == 2'b10);
    assign w_rx_word   = {r_rx_perr, ~r_rx_sync, r_rx_b};

    always_comb begin
        w_rx_state_d = r_rx_state;
        w_rx_s_d     = r_rx_s;
        w_rx_n_d     = r_rx_n;
        w_rx_b_d     = r_rx_b;
        w_rx_pm_d    = r_rx_pm;
        w_rx_perr_d  = r_rx_perr;
        w_rx_push    = 1'b0;
        unique case (r_rx_state)
            RxIdle: if (!r_rx_sync) begin
                w_rx_state_d = RxStart;
                w_rx_s_d     = '0;
                w_rx_pm_d    = parity_mode;
                w_rx_perr_d  = 1'b0;
            end
            RxStart: if (w_tick) begin
                if (r_rx_s == 4'd7) begin
                    w_rx_state_d = r_rx_sync ? RxIdle : RxData;
                    w_rx_s_d     = '0;
                    w_rx_n_d     = '0;
                end else begin
                    w_rx_s_d = r_rx_s + 4'd1;
                end
            end
            RxData: if (w_tick) begin
                if (r_rx_s == 4'd15) begin
                    w_rx_s_d = '0;
                    w_rx_b_d = {r_rx_sync, r_rx_b[DBIT-1:1]};
                    if (r_rx_n == LAST_BIT) begin
                        w_rx_state_d = w_rx_par_en ? RxParity : RxStop;
                    end else begin
                        w_rx_n_d = r_rx_n + 3'd1;
                    end
                end else begin
                    w_rx_s_d = r_rx_s + 4'd1;
                end
            end
            RxParity: if (w_tick) begin
                if (r_rx_s == 4'd15) begin
                    w_rx_s_d     = '0;
                    w_rx_perr_d  = r_rx_sync != (^r_rx_b ^ w_rx_odd);
                    w_rx_state_d = RxStop;
                end else begin
                    w_rx_s_d = r_rx_s + 4'd1;
                end
            end
            RxStop: if (w_tick) begin
                if (r_rx_s == 4'd15) begin
                    w_rx_push    = 1'b1;
                    w_rx_state_d = RxIdle;
                end else begin
                    w_rx_s_d = r_rx_s + 4'd1;
                end
            end
            default: w_rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state <= RxIdle;
            r_rx_s     <= '0;
            r_rx_n     <= '0;
            r_rx_b     <= '0;
            r_rx_pm    <= '0;
            r_rx_perr  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_d;
            r_rx_s     <= w_rx_s_d;
            r_rx_n     <= w_rx_n_d;
            r_rx_b     <= w_rx_b_d;
            r_rx_pm    <= w_rx_pm_d;
            r_rx_perr  <= w_rx_perr_d;
        end
    end

    // RX FIFO; a full FIFO only accepts a push when the head is popped the same cycle.
    logic [RXW-1:0] r_rx_mem [DEPTH];
    logic [FIFO_W:0] r_rx_wp, r_rx_rp;
    logic            w_rx_full, w_rx_wr, w_rx_rd;
    logic [RXW-1:0]  w_rx_head;
    logic            r_ovr;

    assign rx_level  = r_rx_wp - r_rx_rp;
    assign rx_empty  = (rx_level == '0);
    assign w_rx_full = (rx_level == LVL_FULL);
    assign w_rx_rd   = rd_uart && (!rx_empty || w_rx_push);
    assign w_rx_wr   = w_rx_push && (!w_rx_full || rd_uart);
    assign w_rx_head = r_rx_mem[r_rx_rp[FIFO_W-1:0]];
    assign r_data    = w_rx_head[DBIT-1:0];
    assign r_ferr    = !rx_empty && w_rx_head[DBIT];
    assign r_perr    = !rx_empty && w_rx_head[DBIT+1];
    assign overrun   = r_ovr;

    always_ff @(posedge clk) begin
        if (w_rx_wr) r_rx_mem[r_rx_wp[FIFO_W-1:0]] <= w_rx_word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_wp <= '0;
            r_rx_rp <= '0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_rx_wr) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_rd) r_rx_rp <= r_rx_rp + 1'b1;
            if (w_rx_push && w_rx_full && !rd_uart) r_ovr <= 1'b1;
            else if (clr_ovr)                        r_ovr <= 1'b0;
        end
    end

    // TX FIFO
    logic [DBIT-1:0] r_tx_mem [DEPTH];
    logic [FIFO_W:0] r_tx_wp, r_tx_rp;
    logic            w_tx_empty, w_tx_wr, w_tx_pop;
    logic [DBIT-1:0] w_tx_head;

    assign tx_level   = r_tx_wp - r_tx_rp;
    assign w_tx_empty = (tx_level == '0);
    assign tx_full    = (tx_level == LVL_FULL);
    assign w_tx_wr    = wr_uart && (!tx_full || w_tx_pop);
    assign w_tx_head  = r_tx_mem[r_tx_rp[FIFO_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_tx_wr) r_tx_mem[r_tx_wp[FIFO_W-1:0]] <= w_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
        end else begin
            if (w_tx_wr)  r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop) r_tx_rp <= r_tx_rp + 1'b1;
        end
    end

    // TX engine; frames start on a tick so every bit lasts exactly 16 ticks.
    tx_state_e       r_tx_state, w_tx_state_d;
    logic [4:0]      r_tx_s, w_tx_s_d;
    logic [2:0]      r_tx_n, w_tx_n_d;
    logic [DBIT-1:0] r_tx_b, w_tx_b_d;
    logic            r_tx_par, w_tx_par_d, r_tx_par_en, w_tx_par_en_d;
    logic            r_tx_st2, w_tx_st2_d, r_tx, w_tx_d;
    logic            w_tx_stop_last, w_tx_load;

    assign w_tx_stop_last = (r_tx_s == (r_tx_st2 ? 5'd31 : 5'd15));
    assign w_tx_load      = w_tick && !w_tx_empty &&
                            (r_tx_state == TxIdle || (r_tx_state == TxStop && w_tx_stop_last));
    assign w_tx_pop       = w_tx_load;
    assign tx_busy        = (r_tx_state != TxIdle);
    assign tx             = r_tx;

    always_comb begin
        w_tx_state_d  = r_tx_state;
        w_tx_s_d      = r_tx_s;
        w_tx_n_d      = r_tx_n;
        w_tx_b_d      = r_tx_b;
        w_tx_par_d    = r_tx_par;
        w_tx_par_en_d = r_tx_par_en;
        w_tx_st2_d    = r_tx_st2;
        w_tx_d        = r_tx;
        unique case (r_tx_state)
            TxIdle:  w_tx_d = 1'b1;
            TxStart: if (w_tick) begin
                if (r_tx_s == 5'd15) begin
                    w_tx_s_d     = '0;
                    w_tx_state_d = TxData;
                    w_tx_d       = r_tx_b[0];
                end else begin
                    w_tx_s_d = r_tx_s + 5'd1;
                end
            end
            TxData: if (w_tick) begin
                if (r_tx_s == 5'd15) begin
                    w_tx_s_d = '0;
                    w_tx_b_d = r_tx_b >> 1;
                    if (r_tx_n == LAST_BIT) begin
                        w_tx_state_d = r_tx_par_en ? TxParity : TxStop;
                        w_tx_d       = r_tx_par_en ? r_tx_par : 1'b1;
                    end else begin
                        w_tx_n_d = r_tx_n + 3'd1;
                        w_tx_d   = r_tx_b[1];
                    end
                end else begin
                    w_tx_s_d = r_tx_s + 5'd1;
                end
            end
            TxParity: if (w_tick) begin
                if (r_tx_s == 5'd15) begin
                    w_tx_s_d     = '0;
                    w_tx_state_d = TxStop;
                    w_tx_d       = 1'b1;
                end else begin
                    w_tx_s_d = r_tx_s + 5'd1;
                end
            end
            TxStop: if (w_tick) begin
                if (w_tx_stop_last) w_tx_state_d = TxIdle;
                else                w_tx_s_d     = r_tx_s + 5'd1;
            end
            default: w_tx_state_d = TxIdle;
        endcase
        if (w_tx_load) begin
            w_tx_state_d  = TxStart;
            w_tx_s_d      = '0;
            w_tx_n_d      = '0;
            w_tx_b_d      = w_tx_head;
            w_tx_par_en_d = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            w_tx_par_d    = ^w_tx_head ^ (parity_mode == 2'b10);
            w_tx_st2_d    = stop2;
            w_tx_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state  <= TxIdle;
            r_tx_s      <= '0;
            r_tx_n      <= '0;
            r_tx_b      <= '0;
            r_tx_par    <= 1'b0;
            r_tx_par_en <= 1'b0;
            r_tx_st2    <= 1'b0;
            r_tx        <= 1'b1;
        end else begin
            r_tx_state  <= w_tx_state_d;
            r_tx_s      <= w_tx_s_d;
            r_tx_n      <= w_tx_n_d;
            r_tx_b      <= w_tx_b_d;
            r_tx_par    <= w_tx_par_d;
            r_tx_par_en <= w_tx_par_en_d;
            r_tx_st2    <= w_tx_st2_d;
            r_tx        <= w_tx_d;
        end
    end
endmodule

// File: doc/uart_cfg.md
Name: uart_cfg

Overview:
- Parametrised successor to the fixed-format UART: same oversampled RX/TX engines behind RX and TX FIFOs.
- Adds runtime baud divisor, runtime parity (none/even/odd) and stop-bit selection.
- Adds per-word parity and framing error flags carried through the RX FIFO, a sticky overrun flag, FIFO fill levels and a TX busy indicator.
- Sits between the CPU I/O register block and the board pins; intended drop-in for the echo/console designs.

Parameters:
- DBIT, 8, data bits per frame (5..8), LSB first.
- DVSR_BIT, 11, width of the runtime baud divisor input.
- FIFO_W, 4, FIFO address bits; depth = 2^FIFO_W per direction.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- dvsr  in  DVSR_BIT  tick period minus 1; tick rate = clk/(dvsr+1) = 16 x baud.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- stop2  in  1  TX sends 2 stop bits when 1, else 1.
- rx  in  1  serial input, asynchronous.
- rd_uart  in  1  pop RX FIFO head.
- r_data  out  DBIT  RX FIFO head data.
- r_perr  out  1  parity error flag of RX head word.
- r_ferr  out  1  framing error flag of RX head word.
- rx_empty  out  1  RX FIFO empty.
- rx_level  out  FIFO_W+1  RX FIFO occupancy.
- overrun  out  1  sticky: RX word dropped because FIFO full.
- clr_ovr  in  1  clears overrun.
- wr_uart  in  1  push w_data into TX FIFO.
- w_data  in  DBIT  TX data.
- tx_full  out  1  TX FIFO full.
- tx_level  out  FIFO_W+1  TX FIFO occupancy.
- tx_busy  out  1  TX engine not idle.
- tx  out  1  serial output.

Behaviour:
- Reset (async, while reset=0): tx=1, tx_busy=0, rx_empty=1, tx_full=0, both levels=0, overrun=0, r_perr=r_ferr=0, FSMs idle, rx synchroniser flops=1, baud counter=0.
- Baud generator: counter 0..dvsr, one-cycle tick when count==dvsr, then wraps to 0. A dvsr change takes effect at the next wrap. dvsr=0 gives a tick every cycle.
- rx passes through a 2-flop synchroniser before use.
- Config latch: parity_mode and stop2 are captured on entry to START (RX and TX independently) and held for the whole frame. Mid-frame changes do not affect the current frame.
- RX FSM: IDLE -> START on synchronised rx=0.
  - START: at the 8th tick, if rx=1 (false start) -> IDLE with no push; else reset tick count -> DATA.
  - DATA: sample every 16 ticks, DBIT bits, LSB first.
  - PARITY (only if enabled): 16 ticks; perr = received bit != computed parity (even: XOR of data; odd: inverted).
  - STOP: sample at 16th tick; ferr = (rx==0). Push {perr,ferr,data} the same cycle, then -> IDLE. RX checks one stop bit only.
- RX push while FIFO full (and no same-cycle pop): word dropped, overrun set. overrun stays set until clr_ovr=1; set wins if set and clear coincide.
- TX FSM: IDLE -> START when TX FIFO not empty. Head word is latched and popped on that cycle; tx_busy=1 from then until return to IDLE.
  - START: tx=0 for 16 ticks.
  - DATA: DBIT x 16 ticks, LSB first.
  - PARITY (if enabled): 16 ticks.
  - STOP: tx=1 for 16 or 32 ticks.
  - Back-to-back frames need no idle gap.
- FIFOs: first-word fall-through; outputs valid whenever not empty. Simultaneous rd and wr both take effect, including when full or empty with a same-cycle write. Pop when empty is ignored. wr_uart when tx_full is ignored. Level = write count minus read count, range 0..2^FIFO_W.
- tx output is registered; no combinational path from any input to tx.

Test Plan:
- Reset: hold reset=0 mid-TX-frame -> tx=1 same cycle, tx_busy=0, rx_empty=1, levels=0, overrun=0; release -> idle, no spurious frame.
- Loopback (tx->rx), dvsr=3, 8N1: write 0xA5 -> tx low for 64 clk, bits 1,0,1,0,0,1,0,1, high stop; RX head 0xA5, perr=0, ferr=0, rx_level=1.
- Parity: TX even, write 0x07 -> parity bit 1. Receive same frame with RX in odd mode -> r_data=0x07, r_perr=1. Then stop2=1 -> stop high for 128 clk at dvsr=3.
- Framing/false start: 8N1 frame 0x3C with stop driven 0 -> r_data=0x3C, r_ferr=1. rx low pulse of 20 clk (under 8 ticks) -> no push.
- Overrun: FIFO_W=2, receive 5 frames 0x01..0x05 without reading -> rx_level=4, overrun=1, reads return 0x01..0x04; clr_ovr pulse -> overrun=0.
- TX FIFO: FIFO_W=2, 5 writes in consecutive cycles -> tx_full=1 after the 4th is accepted with TX idle; all accepted bytes go out back-to-back in order; simultaneous wr/rd at full keeps tx_level constant.
